// File: rtl/csa_dot_accumulator.sv
// Multi-lane signed carry-save accumulator with a registered carry-propagate output stage.
// Optional CSA_ACC_SATURATE_EN adds 4 guard bits, output clamping and out_ovf.
module csa_dot_accumulator #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   out_ovf
);

`ifdef CSA_ACC_SATURATE_EN
    localparam int unsigned GUARD_W = 4;
`else
    localparam int unsigned GUARD_W = 0;
`endif
    localparam int unsigned SUM_W = ACC_W + GUARD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [SUM_W-1:0] acc_carry_q, acc_carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [SUM_W-1:0] pend_sum_q, pend_sum_d;
    logic [SUM_W-1:0] pend_carry_q, pend_carry_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;
    logic             out_ovf_q, out_ovf_d;

    logic [SUM_W-1:0] csa_s, csa_c, csa_x, csa_cs;
    logic [SUM_W-1:0] red_sum, red_carry;
    logic [CNT_W-1:0] cnt_inc;
    logic [SUM_W-1:0] cpa_full;
    logic [ACC_W-1:0] cpa_res;
    logic             cpa_ovf;
    logic             accept;
    logic             load_b;

    assign in_ready = !(pend_q && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign load_b   = pend_q && (!out_valid_q || out_ready);

    // 3:2 compressor chain; the pair always represents csa_s + 2*csa_c.
    always_comb begin
        csa_s  = acc_sum_q;
        csa_c  = acc_carry_q;
        csa_x  = '0;
        csa_cs = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            csa_x  = SUM_W'($signed(in_data[k*IN_W +: IN_W]));
            csa_cs = csa_c << 1;
            csa_c  = (csa_s & csa_cs) | (csa_s & csa_x) | (csa_cs & csa_x);
            csa_s  = csa_s ^ csa_cs ^ csa_x;
        end
        red_sum   = csa_s;
        red_carry = csa_c;
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Carry-propagate resolution of the pending pair, with optional clamp.
    always_comb begin
        cpa_full = pend_sum_q + (pend_carry_q << 1);
        cpa_res  = cpa_full[ACC_W-1:0];
        cpa_ovf  = 1'b0;
`ifdef CSA_ACC_SATURATE_EN
        if (cpa_full[SUM_W-1:ACC_W-1] != {(GUARD_W+1){cpa_full[SUM_W-1]}}) begin
            cpa_ovf = 1'b1;
            cpa_res = cpa_full[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        acc_sum_d    = acc_sum_q;
        acc_carry_d  = acc_carry_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_sum_d   = pend_sum_q;
        pend_carry_d = pend_carry_q;
        pend_cnt_d   = pend_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_beats_d  = out_beats_q;
        out_ovf_d    = out_ovf_q;

        if (load_b) begin
            pend_d      = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = cpa_res;
            out_beats_d = pend_cnt_q;
            out_ovf_d   = cpa_ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A closing beat bypasses the accumulator straight into the pending pair.
        if (accept) begin
            if (in_last) begin
                pend_d       = 1'b1;
                pend_sum_d   = red_sum;
                pend_carry_d = red_carry;
                pend_cnt_d   = cnt_inc;
                acc_sum_d    = '0;
                acc_carry_d  = '0;
                cnt_d        = '0;
            end else begin
                acc_sum_d    = red_sum;
                acc_carry_d  = red_carry;
                cnt_d        = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum_q    <= '0;
            acc_carry_q  <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_sum_q   <= '0;
            pend_carry_q <= '0;
            pend_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_beats_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            acc_sum_q    <= acc_sum_d;
            acc_carry_q  <= acc_carry_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_sum_q   <= pend_sum_d;
            pend_carry_q <= pend_carry_d;
            pend_cnt_q   <= pend_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_beats_q  <= out_beats_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/csa_dot_accumulator.md
Name: csa_dot_accumulator

Overview:
- Pipelined, parametrised multi-lane signed accumulator for the systolic PE column.
- Each accepted beat carries LANES signed products. The block adds them into a carry-save running sum and never propagates a carry during accumulation.
- A beat marked last closes the group. Its carry-save pair is resolved by a registered carry-propagate stage and presented on a valid/ready output.
- Successor to the single-shot carry-save/carry-propagate adder cells: adds lane count, accumulation depth, grouping and flow control.

Parameters:
- IN_W, 16, width of each signed lane operand.
- LANES, 4, operands per beat; 1..8.
- ACC_W, 32, result width; must be >= IN_W+clog2(LANES).
- CNT_W, 8, width of the beats-per-group counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  LANES*IN_W  lane k occupies bits [k*IN_W +: IN_W], two's complement.
- in_last  in  1  beat closes the current group.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed group sum.
- out_beats  out  CNT_W  number of beats in the group.
- out_ovf  out  1  overflow flag; only driven when SATURATE_EN is defined, else tied 0.

Behaviour:
- Interface: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_beats=0, out_ovf=0. Accumulator sum/carry=0, beat counter=0, result-pair register empty.
- Reset mid-group discards the partial sum. Reset with out_valid=1 drops the held result.
- Accept condition: in_valid & in_ready.
- Stage A (per accepted beat):
  - Sign-extend every lane to ACC_W.
  - A CSA tree reduces the lanes plus acc_sum and acc_carry (carry shifted left 1) to a new sum/carry pair, registered. No CPA in this path.
  - Beat counter increments and saturates at 2^CNT_W-1.
- in_last on an accepted beat:
  - The reduced pair and the count (including this beat) load the result-pair register (pend=1) instead of the accumulator.
  - The accumulator and counter clear to 0 on the same edge.
  - The next beat starts a fresh group with no bubble.
- Stage B: when pend=1 and (out_valid=0 or out_ready=1), a ripple/prefix CPA adds the pair into out_data. It sets out_valid=1, loads out_beats and clears pend.
- Latency: the last beat accepted at edge t gives out_valid=1 after edge t+1. Minimum two cycles from presentation to output.
- Output handshake: out_data, out_beats and out_ovf hold stable while out_valid & !out_ready. out_valid falls after the edge where out_ready=1 unless a new result loads on that same edge; back-to-back results are allowed.
- in_ready = !(pend & out_valid & !out_ready). The block stalls only when the result register is full and the output is blocked. Non-last beats stall too under that condition.
- Simultaneous events:
  - out_ready=1 with pend=1 on the same edge: old result leaves, new result loads.
  - in_last accepted while pend is draining: legal, since in_ready already guarantees space.
- in_valid=0 cycles leave all state unchanged; groups may be sparse.
- A single-beat group (in_last on the first beat) is legal: out_beats=1.
- Arithmetic without SATURATE_EN wraps modulo 2^ACC_W.

Optional Feature:
- Macro: CSA_ACC_SATURATE_EN.
- Defined:
  - Accumulator and CPA carry 4 extra guard MSBs (ACC_W+4).
  - Stage B clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) when the guarded result is out of range, and sets out_ovf=1 for that result.
  - Overflow beyond the guard bits within a group is unspecified.
- Undefined: no guard bits, results wrap, out_ovf tied 0.

Test Plan:
- LANES=4, IN_W=16, ACC_W=32. One beat {1,2,3,4} with last -> out_data=10, out_beats=1, out_valid two cycles after presentation.
- Three beats of {-1,-1,-1,-1}, last on the third, out_ready=1 -> out_data=-12 (0xFFFFFFF4), out_beats=3. The next group starts on the following cycle without a bubble.
- Two groups back to back with out_ready held 0 -> first result held stable; pend fills; in_ready=0. Raise out_ready -> results {group1, group2} delivered in order on consecutive cycles.
- Assert rst for one cycle after 5 non-last beats -> then a one-beat group {7,0,0,0} with last gives out_data=7, out_beats=1 (no residue).
- Without the macro: 2^CNT_W+3 beats of {0,0,0,1} then last -> out_beats saturates at 255, out_data=260 (ACC_W wide).
- With CSA_ACC_SATURATE_EN, ACC_W=20: 20 beats of {32767×4} -> out_data=524287, out_ovf=1. Without the macro -> out_data is the sum mod 2^20, out_ovf=0.
